// File: rtl/qsgmii_fifo_rr_sched.sv
// Four-channel round-robin frame scheduler: drains whole frames from FWFT FIFOs
// onto one registered output stream, with length-cut and stall-abort protection.
module qsgmii_fifo_rr_sched #(
  parameter int DATA_WIDTH    = 9,
  parameter int MAX_WORDS     = 2048,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                ch_empty,
  input  logic [4*DATA_WIDTH-1:0]   ch_rd_data,
  output logic [3:0]                ch_rd_en,
  input  logic [3:0]                cfg_ch_en,
  output logic [DATA_WIDTH-2:0]     m_data,
  output logic                      m_last,
  output logic                      m_err,
  output logic [1:0]                m_ch,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      err_len,
  output logic                      err_stall
);
  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int SCW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

  state_t                  state_q;
  logic [1:0]              grant_q;
  logic [1:0]              last_grant_q;
  logic [WCW-1:0]          word_cnt_q;
  logic [SCW-1:0]          stall_cnt_q;
  logic [DATA_WIDTH-2:0]   m_data_q;
  logic                    m_last_q;
  logic                    m_err_q;
  logic [1:0]              m_ch_q;
  logic                    m_valid_q;
  logic                    err_len_q;
  logic                    err_stall_q;

  logic [DATA_WIDTH-1:0]   ch_word [4];
  logic [DATA_WIDTH-1:0]   head_w;
  logic [3:0]              cand;
  logic [1:0]              pick_d;
  logic                    out_free;
  logic                    pop;
  logic                    cut;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign ch_word[gi] = ch_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cand     = cfg_ch_en & ~ch_empty;
  assign head_w   = ch_word[grant_q];
  assign out_free = ~m_valid_q | m_ready;
  assign pop      = (state_q == XFER) & ~ch_empty[grant_q] & out_free;
  assign cut      = (word_cnt_q == WCW'(MAX_WORDS - 1));

  // Lowest cyclic offset from last_grant wins, so it is evaluated last.
  always_comb begin
    pick_d = last_grant_q;
    for (int i = 4; i >= 1; i--) begin
      if (cand[last_grant_q + 2'(i)]) pick_d = last_grant_q + 2'(i);
    end
  end

  always_comb begin
    ch_rd_en = 4'b0000;
    ch_rd_en[grant_q] = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      word_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_err_q      <= 1'b0;
      m_ch_q       <= 2'd0;
      m_valid_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_stall_q  <= 1'b0;
    end else begin
      err_len_q   <= 1'b0;
      err_stall_q <= 1'b0;
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|cand) begin
            grant_q     <= pick_d;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            m_data_q    <= head_w[DATA_WIDTH-2:0];
            m_last_q    <= head_w[DATA_WIDTH-1] | cut;
            m_err_q     <= 1'b0;
            m_ch_q      <= grant_q;
            m_valid_q   <= 1'b1;
            word_cnt_q  <= word_cnt_q + 1'b1;
            stall_cnt_q <= '0;
            if (head_w[DATA_WIDTH-1] || cut) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
              err_len_q    <= ~head_w[DATA_WIDTH-1];
            end
          end else if (ch_empty[grant_q]) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
            if (stall_cnt_q == SCW'(STALL_TIMEOUT - 1)) begin
              err_stall_q <= 1'b1;
              state_q     <= ABORT;
            end
          end
        end
        ABORT: begin
          // Close the broken frame with an error terminator word.
          if (out_free) begin
            m_data_q     <= '0;
            m_last_q     <= 1'b1;
            m_err_q      <= 1'b1;
            m_ch_q       <= grant_q;
            m_valid_q    <= 1'b1;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_err     = m_err_q;
  assign m_ch      = m_ch_q;
  assign m_valid   = m_valid_q;
  assign busy      = (state_q != IDLE);
  assign err_len   = err_len_q;
  assign err_stall = err_stall_q;
endmodule

// File: doc/qsgmii_fifo_rr_sched.md
QSGMII_FIFO_RR_SCHED -- requirements
Module: qsgmii_fifo_rr_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 9, meaning: FIFO word width; bit DATA_WIDTH-1 is the end-of-frame flag, bits DATA_WIDTH-2:0 are payload.
REQ-002 Parameter MAX_WORDS, default 2048, meaning: maximum words per frame before a forced frame cut.
REQ-003 Parameter STALL_TIMEOUT, default 64, meaning: consecutive mid-frame empty cycles before a frame abort.
REQ-004 The channel count SHALL be fixed at 4, with channel index width 2.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ch_empty  input  4  per-channel FIFO empty flag; a channel FIFO presents its head word on ch_rd_data combinationally (first-word fall-through) while not empty.
REQ-008 ch_rd_data  input  4*DATA_WIDTH  per-channel FIFO head word; channel n occupies bits n*DATA_WIDTH +: DATA_WIDTH.
REQ-009 ch_rd_en  output  4  per-channel FIFO read strobe (pops the head word).
REQ-010 cfg_ch_en  input  4  per-channel arbitration enable.
REQ-011 m_data  output  DATA_WIDTH-1  output payload.
REQ-012 m_last  output  1  last word of the output frame.
REQ-013 m_err  output  1  frame aborted; valid with m_last.
REQ-014 m_ch  output  2  source channel of the current output word.
REQ-015 m_valid  output  1  output word valid.
REQ-016 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.
REQ-017 busy  output  1  high when the FSM is not IDLE.
REQ-018 err_len  output  1  single-cycle pulse on a MAX_WORDS cut.
REQ-019 err_stall  output  1  single-cycle pulse on a stall abort.

Function
REQ-020 The FSM SHALL have three states: IDLE, XFER and ABORT.
REQ-021 IDLE: the candidate set is cfg_ch_en & ~ch_empty; if it is non-empty, the block SHALL register grant g as the first candidate searching cyclically from last_grant+1, and enter XFER on the next cycle.
REQ-022 XFER: ch_rd_en[g] SHALL equal ~ch_empty[g] & (~m_valid | m_ready); all other ch_rd_en bits SHALL be 0; ch_rd_en SHALL be 0 in IDLE and ABORT.
REQ-023 On each pop, the output register SHALL load m_data = payload, m_last = EOF bit, m_err = 0, m_ch = g, m_valid = 1.
REQ-024 A popped word with EOF=1 SHALL cause a transition to IDLE on the same edge, with last_grant <= g.
REQ-025 A word counter SHALL clear on entry to XFER and increment per pop; if the MAX_WORDS-th pop has EOF=0, the block SHALL force m_last=1, pulse err_len, and enter IDLE with last_grant <= g; the remainder of that frame is arbitrated as a new frame.
REQ-026 A stall counter SHALL count consecutive XFER cycles with ch_empty[g]=1 and clear on any pop; when it reaches STALL_TIMEOUT, the block SHALL pulse err_stall and enter ABORT.
REQ-027 ABORT: when ~m_valid | m_ready, the block SHALL load m_data=0, m_last=1, m_err=1, m_ch=g, m_valid=1, set last_grant <= g, and enter IDLE.
REQ-028 While m_valid & ~m_ready, m_data, m_last, m_err and m_ch SHALL hold stable; m_valid SHALL clear on acceptance unless a new word loads on the same edge.
REQ-029 Within a frame, throughput SHALL be 1 word/cycle when ch_empty[g]=0 and m_ready=1; frame-to-frame gap SHALL be exactly one IDLE cycle.
REQ-030 Deasserting cfg_ch_en[g] mid-frame SHALL NOT interrupt the frame; it affects only later arbitration.
REQ-031 No FIFO SHALL be popped while it is empty; no words SHALL be dropped or duplicated.

Reset
REQ-032 With rst_n low: FSM=IDLE; last_grant=3, so ch0 has first priority; counters=0; ch_rd_en, m_data, m_last, m_err, m_ch, m_valid, busy, err_len and err_stall all 0.
REQ-033 Reset mid-frame SHALL abandon the frame immediately; no further pops SHALL occur until rst_n is high and IDLE arbitration has run.

Verification
REQ-034 Round robin: all channels hold one 3-word frame, m_ready=1 -> output frames in channel order 0,1,2,3; each frame is 3 consecutive m_valid cycles with m_last on the third word, with 1 gap cycle between frames.
REQ-035 Backpressure: m_ready toggles 1010 during a 5-word ch2 frame -> exactly 5 pops; every word is held stable until accepted; order is preserved.
REQ-036 Length cut: MAX_WORDS=4, ch1 frame of 6 words -> 4th word has m_last=1 and err_len pulses; the next ch1 arbitration delivers 2 words ending with EOF.
REQ-037 Stall: STALL_TIMEOUT=8, ch3 empties after 2 words of a frame -> err_stall pulses after 8 empty cycles; a word with m_data=0, m_last=1, m_err=1, m_ch=3 follows.
REQ-038 Mask and reset: cfg_ch_en=4'b1010, all channels non-empty -> only ch1/ch3 are granted; asserting rst_n low mid-frame -> all outputs 0 within the same cycle.
